// File: rtl/key_entry_pkg.sv
// Shared types and constants for the key entry controller: FSM states,
// button pulse indices and the BCD digit type with wrap-around helpers.
package key_entry_pkg;

  typedef enum logic [1:0] {
    EDIT = 2'd0,
    CONV = 2'd1,
    REQ  = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;
  localparam int BTN_CUR = 2;
  localparam int BTN_ENT = 3;
  localparam int BTN_CLR = 4;

  typedef logic [3:0] bcd_t;

  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

endpackage

// File: rtl/key_entry_if.sv
// Button, core handshake and display signals of the key entry controller.
// master = controller side, slave = debouncer/core/display side.
interface key_entry_if #(
  parameter int DIGITS = 4,
  parameter int W      = 14
);
  logic [4:0]                 bin;
  logic                       req_ready;
  logic                       done;
  logic [4*DIGITS-1:0]        digit_bcd;
  logic [$clog2(DIGITS)-1:0]  cursor;
  logic [W-1:0]               value;
  logic                       req_valid;
  logic                       busy;
  logic                       abort;
  logic                       err;

  modport master (
    input  bin, req_ready, done,
    output digit_bcd, cursor, value, req_valid, busy, abort, err
  );

  modport slave (
    output bin, req_ready, done,
    input  digit_bcd, cursor, value, req_valid, busy, abort, err
  );
endinterface

// File: rtl/key_entry_bcd2bin.sv
// Serial BCD-to-binary converter: folds one digit per cycle, most significant
// first, into a times-ten accumulator; pulses done after digit 0.
module key_entry_bcd2bin
  import key_entry_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int W      = 14
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  bcd_t [DIGITS-1:0]        digits,
  output logic                     done,
  output logic [W-1:0]             result
);
  localparam int IDX_W = $clog2(DIGITS);

  logic [IDX_W-1:0] idx;
  logic             active;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_nxt;

  // acc*10 as two shifts; truncation to W is intentional
  assign acc_nxt = (acc << 3) + (acc << 1) + W'(digits[idx]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx    <= '0;
      active <= 1'b0;
      acc    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= '0;
        idx    <= IDX_W'(DIGITS - 1);
        active <= 1'b1;
      end else if (active) begin
        acc <= acc_nxt;
        if (idx == '0) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          idx <= idx - 1'b1;
        end
      end
    end
  end

  assign result = acc;

endmodule

// File: rtl/key_entry_ctrl.sv
// Key entry sequencer: digit bank editing, BCD conversion and core start handshake.
// Build option KEY_ENTRY_MIN_CHECK_EN rejects converted values below 2 with an ERR pulse.
module key_entry_ctrl
  import key_entry_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int W      = 14
) (
  input  logic CLK,
  input  logic RST,
  key_entry_if.master kif
);
  // state | meaning
  // EDIT  | buttons edit digits/cursor; ENTER starts conversion
  // CONV  | serial BCD->binary, all buttons ignored
  // REQ   | REQ_VALID high, waiting for core; CLEAR aborts
  // RUN   | BUSY high until DONE; CLEAR aborts

  localparam int CUR_W = $clog2(DIGITS);

  state_t            state, state_nxt;
  bcd_t [DIGITS-1:0] digits;
  logic [CUR_W-1:0]  cursor;
  logic [W-1:0]      value;
  logic              abort_r;
  logic [4:0]        bin;
  logic              conv_start;
  logic              conv_done;
  logic [W-1:0]      conv_result;
  logic              do_load;
  logic              do_abort;
`ifdef KEY_ENTRY_MIN_CHECK_EN
  logic              do_err;
  logic              err_r;
`endif

  assign bin = kif.bin;

  key_entry_bcd2bin #(.DIGITS(DIGITS), .W(W)) u_bcd2bin (
    .CLK    (CLK),
    .RST    (RST),
    .start  (conv_start),
    .digits (digits),
    .done   (conv_done),
    .result (conv_result)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= EDIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    conv_start = 1'b0;
    do_load    = 1'b0;
    do_abort   = 1'b0;
`ifdef KEY_ENTRY_MIN_CHECK_EN
    do_err     = 1'b0;
`endif
    case (state)
      EDIT: begin
        if (!bin[BTN_CLR] && bin[BTN_ENT]) begin
          conv_start = 1'b1;
          state_nxt  = CONV;
        end
      end
      CONV: begin
        if (conv_done) begin
`ifdef KEY_ENTRY_MIN_CHECK_EN
          if (conv_result < W'(2)) begin
            do_err    = 1'b1;
            state_nxt = EDIT;
          end else begin
            do_load   = 1'b1;
            state_nxt = REQ;
          end
`else
          do_load   = 1'b1;
          state_nxt = REQ;
`endif
        end
      end
      REQ: begin
        // handshake takes precedence over a simultaneous CLEAR
        if (kif.req_ready) begin
          state_nxt = RUN;
        end else if (bin[BTN_CLR]) begin
          do_abort  = 1'b1;
          state_nxt = EDIT;
        end
      end
      RUN: begin
        if (kif.done) begin
          state_nxt = EDIT;
        end else if (bin[BTN_CLR]) begin
          do_abort  = 1'b1;
          state_nxt = EDIT;
        end
      end
      default: state_nxt = EDIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      digits  <= '0;
      cursor  <= '0;
      value   <= '0;
      abort_r <= 1'b0;
    end else begin
      abort_r <= do_abort;
      if (do_load) value <= conv_result;
      if (state == EDIT) begin
        if (bin[BTN_CLR]) begin
          digits <= '0;
          cursor <= '0;
          value  <= '0;
        end else if (bin[BTN_ENT]) begin
          cursor <= cursor;
        end else if (bin[BTN_CUR]) begin
          if (cursor == CUR_W'(DIGITS - 1)) cursor <= '0;
          else                              cursor <= cursor + 1'b1;
        end else if (bin[BTN_INC]) begin
          digits[cursor] <= bcd_inc(digits[cursor]);
        end else if (bin[BTN_DEC]) begin
          digits[cursor] <= bcd_dec(digits[cursor]);
        end
      end
    end
  end

`ifdef KEY_ENTRY_MIN_CHECK_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_r <= 1'b0;
    else     err_r <= do_err;
  end
  assign kif.err = err_r;
`else
  assign kif.err = 1'b0;
`endif

  assign kif.digit_bcd = digits;
  assign kif.cursor    = cursor;
  assign kif.value     = value;
  assign kif.req_valid = (state == REQ);
  assign kif.busy      = (state == RUN);
  assign kif.abort     = abort_r;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed testbench for key_entry_ctrl (DIGITS=4, W=14); honours KEY_ENTRY_MIN_CHECK_EN.
module tb_key_entry_ctrl;
  localparam logic [4:0] B_INC = 5'b00001;
  localparam logic [4:0] B_DEC = 5'b00010;
  localparam logic [4:0] B_CUR = 5'b00100;
  localparam logic [4:0] B_ENT = 5'b01000;
  localparam logic [4:0] B_CLR = 5'b10000;

  logic clk;
  logic rst;
  int   nvec;
  int   nmis;

  key_entry_if #(.DIGITS(4), .W(14)) kif ();

  key_entry_ctrl #(.DIGITS(4), .W(14)) dut (
    .CLK (clk),
    .RST (rst),
    .kif (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      kif.bin = m;
      step();
      kif.bin = 5'b0;
    end
  endtask

  task automatic enter_to_req();
    press(B_ENT, 1);
    repeat (5) step();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_digits"}, 32'(kif.digit_bcd), 32'h0);
    check_eq({tag, "_cursor"}, 32'(kif.cursor), 32'h0);
    check_eq({tag, "_value"}, 32'(kif.value), 32'h0);
    check_eq({tag, "_req_valid"}, 32'(kif.req_valid), 32'h0);
    check_eq({tag, "_busy"}, 32'(kif.busy), 32'h0);
    check_eq({tag, "_abort"}, 32'(kif.abort), 32'h0);
    check_eq({tag, "_err"}, 32'(kif.err), 32'h0);
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    rst = 1'b1;
    kif.bin = 5'b0;
    kif.req_ready = 1'b0;
    kif.done = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // basic editing with DEC wrap
    press(B_INC, 3);
    press(B_CUR, 1);
    press(B_INC, 1);
    press(B_DEC, 2);
    check_eq("edit_digits", 32'(kif.digit_bcd), 32'h0093);
    check_eq("edit_cursor", 32'(kif.cursor), 32'd1);

    press(B_CUR, 3);
    check_eq("cursor_wrap", 32'(kif.cursor), 32'd0);

    press(B_INC | B_DEC | B_CUR, 1);
    check_eq("prio_cursor", 32'(kif.cursor), 32'd1);
    check_eq("prio_digits", 32'(kif.digit_bcd), 32'h0093);

    press(B_CLR | B_INC, 1);
    check_eq("clear_digits", 32'(kif.digit_bcd), 32'h0);
    check_eq("clear_cursor", 32'(kif.cursor), 32'd0);

    // build 1234
    press(B_INC, 4); press(B_CUR, 1);
    press(B_INC, 3); press(B_CUR, 1);
    press(B_INC, 2); press(B_CUR, 1);
    press(B_INC, 1);
    check_eq("digits_1234", 32'(kif.digit_bcd), 32'h1234);
    check_eq("cursor_3", 32'(kif.cursor), 32'd3);

    // conversion latency: REQ_VALID exactly 5 cycles after ENTER edge
    press(B_ENT, 1);
    check_eq("conv_rv_0", 32'(kif.req_valid), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      kif.bin = B_CLR;
      step();
      kif.bin = 5'b0;
      check_eq($sformatf("conv_rv_%0d", k), 32'(kif.req_valid), (k == 5) ? 32'd1 : 32'd0);
    end
    check_eq("value_1234", 32'(kif.value), 32'd1234);

    // request held without ready; other buttons ignored
    for (int k = 0; k < 10; k++) begin
      kif.bin = (k == 3) ? B_INC : 5'b0;
      step();
      kif.bin = 5'b0;
      check_eq($sformatf("hold_rv_%0d", k), 32'(kif.req_valid), 32'd1);
      check_eq($sformatf("hold_val_%0d", k), 32'(kif.value), 32'd1234);
    end
    check_eq("hold_digits", 32'(kif.digit_bcd), 32'h1234);

    kif.req_ready = 1'b1;
    step();
    kif.req_ready = 1'b0;
    check_eq("hs_busy", 32'(kif.busy), 32'd1);
    check_eq("hs_rv", 32'(kif.req_valid), 32'd0);

    // DONE beats CLEAR
    kif.done = 1'b1;
    kif.bin = B_CLR;
    step();
    kif.done = 1'b0;
    kif.bin = 5'b0;
    check_eq("done_busy", 32'(kif.busy), 32'd0);
    check_eq("done_abort", 32'(kif.abort), 32'd0);
    check_eq("done_digits", 32'(kif.digit_bcd), 32'h1234);
    step();
    check_eq("done_abort2", 32'(kif.abort), 32'd0);

    // CLEAR during RUN
    enter_to_req();
    check_eq("run_rv", 32'(kif.req_valid), 32'd1);
    kif.req_ready = 1'b1;
    step();
    kif.req_ready = 1'b0;
    check_eq("run_busy", 32'(kif.busy), 32'd1);
    press(B_CLR, 1);
    check_eq("run_abort", 32'(kif.abort), 32'd1);
    check_eq("run_abort_busy", 32'(kif.busy), 32'd0);
    step();
    check_eq("run_abort_1cyc", 32'(kif.abort), 32'd0);
    check_eq("run_abort_digits", 32'(kif.digit_bcd), 32'h1234);

    // CLEAR with REQ_READY: handshake wins
    enter_to_req();
    kif.req_ready = 1'b1;
    kif.bin = B_CLR;
    step();
    kif.req_ready = 1'b0;
    kif.bin = 5'b0;
    check_eq("req_clr_rdy_busy", 32'(kif.busy), 32'd1);
    check_eq("req_clr_rdy_abort", 32'(kif.abort), 32'd0);
    kif.done = 1'b1;
    step();
    kif.done = 1'b0;
    check_eq("req_clr_rdy_done", 32'(kif.busy), 32'd0);

    // CLEAR alone in REQ
    enter_to_req();
    press(B_CLR, 1);
    check_eq("req_abort", 32'(kif.abort), 32'd1);
    check_eq("req_abort_rv", 32'(kif.req_valid), 32'd0);
    check_eq("req_abort_digits", 32'(kif.digit_bcd), 32'h1234);

    // async reset mid-CONV
    press(B_ENT, 1);
    step();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    rst = 1'b0;
    step();

    // 9999 without truncation
    press(B_DEC, 1); press(B_CUR, 1);
    press(B_DEC, 1); press(B_CUR, 1);
    press(B_DEC, 1); press(B_CUR, 1);
    press(B_DEC, 1);
    check_eq("digits_9999", 32'(kif.digit_bcd), 32'h9999);
    enter_to_req();
    check_eq("value_9999", 32'(kif.value), 32'd9999);
    check_eq("rv_9999", 32'(kif.req_valid), 32'd1);
    press(B_CLR, 1);
    check_eq("abort_9999", 32'(kif.abort), 32'd1);
    press(B_CLR, 1);
    check_eq("clear_value", 32'(kif.value), 32'd0);
    check_eq("clear_digits2", 32'(kif.digit_bcd), 32'h0);

    // minimum value check
    press(B_INC, 1);
    check_eq("digits_0001", 32'(kif.digit_bcd), 32'h0001);
    press(B_ENT, 1);
    repeat (4) step();
    check_eq("min_err_early", 32'(kif.err), 32'd0);
    step();
`ifdef KEY_ENTRY_MIN_CHECK_EN
    check_eq("min_err", 32'(kif.err), 32'd1);
    check_eq("min_rv", 32'(kif.req_valid), 32'd0);
    step();
    check_eq("min_err_1cyc", 32'(kif.err), 32'd0);
    check_eq("min_rv2", 32'(kif.req_valid), 32'd0);
    check_eq("min_digits", 32'(kif.digit_bcd), 32'h0001);
`else
    check_eq("min_err", 32'(kif.err), 32'd0);
    check_eq("min_rv", 32'(kif.req_valid), 32'd1);
    check_eq("min_value", 32'(kif.value), 32'd1);
    press(B_CLR, 1);
    check_eq("min_abort", 32'(kif.abort), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/key_entry_ctrl.md
# key_entry_ctrl

Sequencing controller between the debounced push-button block and the factorization core. It turns single-cycle button pulses into a DIGITS-wide decimal entry buffer with a cursor for the display. On ENTER it serially converts the BCD buffer to binary, offers the value to the core over a valid/ready request, and tracks the core until done or abort. It is the only block that drives the core's start handshake.

## Interface
- DIGITS, 4, number of decimal digits in the entry buffer (2..8)
- W, 14, width of the binary value; must satisfy 10^DIGITS − 1 < 2^W
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high; all state and outputs go to reset values immediately
- BIN  in  5  one-cycle button pulses from the debouncer: [0] INC, [1] DEC, [2] CURSOR, [3] ENTER, [4] CLEAR
- REQ_READY  in  1  core accepts request
- DONE  in  1  one-cycle pulse from the core: computation finished
- DIGIT_BCD  out  4*DIGITS  entry buffer, digit i at [4i+3:4i], digit 0 least significant; reset 0
- CURSOR  out  $clog2(DIGITS)  index of the edited digit; reset 0
- VALUE  out  W  converted binary value; reset 0; stable while REQ_VALID or BUSY
- REQ_VALID  out  1  request to core; reset 0
- BUSY  out  1  core is working on VALUE; reset 0
- ABORT  out  1  one-cycle pulse: user cancelled; reset 0
- ERR  out  1  one-cycle pulse: ENTER rejected; reset 0 (only with macro)

## Operation
- States: EDIT (reset), CONV, REQ, RUN.
- EDIT: at most one button acts per cycle, priority CLEAR > ENTER > CURSOR > INC > DEC; lower-priority pulses in the same cycle are discarded.
  - INC: digit[CURSOR] +1, 9 wraps to 0. DEC: −1, 0 wraps to 9.
  - CURSOR: CURSOR +1, DIGITS−1 wraps to 0.
  - CLEAR: all digits 0, CURSOR 0, VALUE 0.
  - ENTER: go to CONV, accumulator cleared, digit index = DIGITS−1.
- CONV: one digit per cycle, most-significant first: acc = ((acc<<3)+(acc<<1) + digit[idx]) truncated to W. After digit 0 is folded in, VALUE = acc and the state goes to REQ. All buttons are ignored, including CLEAR.
- REQ: REQ_VALID = 1.
  - REQ_READY = 1: go to RUN.
  - CLEAR: ABORT pulse, go to EDIT, digits kept.
  - CLEAR and REQ_READY in the same cycle: the handshake wins.
- RUN: BUSY = 1.
  - DONE: go to EDIT.
  - CLEAR: ABORT pulse, go to EDIT.
  - DONE and CLEAR in the same cycle: DONE wins, no ABORT.
- DONE outside RUN and REQ_READY outside REQ are ignored.
- Digits are editable only in EDIT. Buttons other than CLEAR are ignored in REQ and RUN.

## Timing
- Button action is visible on DIGIT_BCD/CURSOR one cycle after the pulse edge.
- ENTER sampled at edge t: CONV for DIGITS cycles; VALUE valid and REQ_VALID = 1 from edge t+DIGITS+1.
- Handshake completes on the edge where REQ_VALID && REQ_READY; REQ_VALID = 0 and BUSY = 1 on the next cycle.
- DONE at edge d: BUSY = 0 from d+1; a new ENTER is accepted from d+1.
- ABORT and ERR are registered outputs, high for exactly one cycle after the triggering edge.
- Reset mid-CONV, REQ or RUN returns to EDIT with all outputs at reset values. No request is left pending.

## Configuration
- KEY_ENTRY_MIN_CHECK_EN defined: the EDIT→CONV→REQ path is unchanged except at the end of CONV. If the converted value < 2, the controller pulses ERR and returns to EDIT with digits kept, and REQ_VALID never rises.
- Not defined: every value, including 0 and 1, is requested. The ERR port exists and is tied 0.

## Structure
- Package key_entry_pkg holds:
  - the state enum (EDIT, CONV, REQ, RUN);
  - button index constants BTN_INC=0, BTN_DEC=1, BTN_CUR=2, BTN_ENT=3, BTN_CLR=4;
  - the BCD digit type.
- One sub-module, key_entry_bcd2bin:
  - owns the serial multiply-by-10 accumulator and digit index;
  - start/done interface.
- The FSM, digit bank and handshake stay in key_entry_ctrl.

## Test plan
- Reset, then INC×3, CURSOR, INC×1, DEC×2 → DIGIT_BCD = 16'h0_0_9_3, CURSOR = 1.
- Digits 1,2,3,4 (digit3..0), ENTER → VALUE = 1234 and REQ_VALID = 1 exactly 5 cycles after ENTER; REQ_READY held 0 for 10 cycles → REQ_VALID and VALUE stable.
- REQ_READY = 1 one cycle → BUSY = 1 next cycle; DONE and CLEAR in the same cycle → BUSY = 0, no ABORT, digits still 1234.
- Same cycle INC+DEC+CURSOR in EDIT → only CURSOR moves. CLEAR during RUN → one-cycle ABORT, state EDIT. Async RST mid-CONV → all outputs 0 immediately.
- Digits 9999 with DIGITS=4, W=14 → VALUE = 9999, no truncation.
- With KEY_ENTRY_MIN_CHECK_EN: digits 0001, ENTER → one-cycle ERR at ENTER+5, REQ_VALID stays 0. Without the macro → REQ_VALID = 1 with VALUE = 1.
